nibbler_run_ctrl: RTL and testbench
===================================

// Module: nibbler_run_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the Nibbler 4-bit core. Produces one clock enable, core_en, that gates
//  every core register: PC, Phase, Fetch, A and Flags. Halts only on instruction boundaries (end of phase 1).
//  Adds one PC breakpoint and a saturating count of executed core cycles, for debug and bring-up.
// PARAMETERS
//  ADDR_W        12  width of pc / bp_addr (core program address)
//  CYC_W         16  width of cycle_cnt
//  RUN_ON_RESET  1   1: state after reset is RUN (free-running core); 0: state after reset is HALT
// PORTS
//  clk        in   1       core clock; all state changes on rising edge
//  Rst        in   1       asynchronous, active-low reset (0 = reset asserted)
//  run_req    in   1       1-cycle pulse: resume free running
//  halt_req   in   1       1-cycle pulse: stop at next instruction boundary
//  step_req   in   1       1-cycle pulse: execute exactly one instruction, then halt
//  cnt_clr    in   1       synchronous clear of cycle_cnt
//  phase      in   1       core Phase output: 0 = fetch cycle, 1 = execute cycle
//  pc         in   ADDR_W  core PC (fetch address, valid while phase=0)
//  bp_addr    in   ADDR_W  breakpoint address
//  bp_en      in   1       breakpoint enable
//  core_en    out  1       clock enable to all core registers (combinational from state and inputs)
//  halted     out  1       1 while state = HALT
//  bp_hit     out  1       sticky: last halt was caused by the breakpoint
//  step_done  out  1       1-cycle pulse: single step finished
//  cycle_cnt  out  CYC_W   number of cycles with core_en=1 (saturating)
//  state      out  2       00 HALT, 01 RUN, 10 STEP (11 unused, decodes as HALT)
// BEHAVIOUR
//  - Reset (Rst=0, async): state=RUN if RUN_ON_RESET else HALT. bp_hit=0, step_done=0, cycle_cnt=0,
//    halt_pend=0, bp_skip=0. halted=!RUN_ON_RESET. Reset mid-STEP or mid-RUN aborts with no step_done.
//    The core shares Rst, so phase=0 after reset.
//  - Boundary edge: rising edge with core_en=1 and phase=1.
//  - bp_match = bp_en & (pc==bp_addr) & (phase==0) & !bp_skip.
//  - HALT: core_en=0. Same-cycle priority: run_req -> RUN; else step_req -> STEP. halt_req ignored.
//    run_req or step_req clears bp_hit. Leaving HALT with bp_hit=1 sets bp_skip=1.
//  - RUN: core_en = !bp_match.
//    - bp_match cycle: -> HALT, bp_hit=1. PC stays at bp_addr, nothing fetched.
//    - halt_req sets halt_pend. Next boundary edge with halt_pend (or halt_req in that same cycle) -> HALT, halt_pend=0.
//    - If a breakpoint and a pending halt coincide, the breakpoint wins (bp_hit=1).
//    - run_req and step_req are ignored.
//  - STEP: core_en=1; breakpoint not checked. Boundary edge -> HALT, step_done=1 for exactly one cycle.
//    A step is two core cycles. halt_req, run_req and step_req are ignored.
//  - bp_skip clears on the first boundary edge after it is set. Resuming from a breakpoint therefore executes
//    the instruction at bp_addr once.
//  - cycle_cnt increments by 1 on every edge with core_en=1. Holds at all-ones (no wrap).
//    cnt_clr has priority: cycle_cnt=0 even if an increment is due in the same cycle.
//  - pc/bp_addr compare is full ADDR_W equality. PC wrap 0xFFF->0x000 needs no special case.
// TESTING
//  1 RUN_ON_RESET=0: release Rst, idle 4 clk -> core_en=0, halted=1, cycle_cnt=0.
//    Pulse step_req -> core_en=1 for exactly 2 clk; step_done=1 on the following cycle;
//    halted=1, cycle_cnt=2, PC advanced by one instruction.
//  2 RUN, bp_en=1, bp_addr=12'h005, straight-line program -> core_en=0 in the cycle phase=0 and pc=5.
//    Next cycle halted=1, bp_hit=1; pc stays 5 for 10 clk.
//  3 From case 2, pulse run_req -> bp_hit=0, instruction at 5 executes (no re-trigger), pc reaches 6.
//    With a jump back to 5: halts again at 5, bp_hit=1.
//  4 RUN, pulse halt_req while phase=0 -> core_en stays 1 through phase 1; halted=1 with phase=0.
//    Repeat with halt_req during phase=1 -> halts at that same boundary.
//  5 In HALT, pulse run_req and step_req together -> state=RUN, no step_done.
//    CYC_W=4, run 20 clk -> cycle_cnt=15 (held). cnt_clr in an incrementing cycle -> 0.
//  6 Assert Rst=0 asynchronously between clock edges during STEP -> outputs take reset values immediately,
//    step_done never asserted.
//    RUN_ON_RESET=1 -> core_en=1 after release.

Source files
------------

// File: rtl/nibbler_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibbler_run_ctrl
//  Description : Run / halt / single-step sequencer for the Nibbler 4-bit
//                core. Drives the single clock enable (core_en) that gates
//                every core register, stops only on instruction boundaries,
//                provides one PC breakpoint and a saturating count of
//                executed core cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibbler_run_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int CYC_W        = 16,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              cnt_clr,
    input  logic              phase,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              core_en,
    output logic              halted,
    output logic              bp_hit,
    output logic              step_done,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam state_t           C_RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;
    localparam logic [CYC_W-1:0] C_CNT_MAX     = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] C_CNT_ONE     = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t           state_q,     state_d;
    logic             bp_hit_q,    bp_hit_d;
    logic             step_done_q, step_done_d;
    logic             halt_pend_q, halt_pend_d;
    logic             bp_skip_q,   bp_skip_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic w_bp_match;
    logic w_core_en;
    logic w_boundary;

    // Breakpoint only fires on a fetch cycle and is masked for the one
    // instruction being resumed from a breakpoint halt.
    assign w_bp_match = bp_en & (pc == bp_addr) & ~phase & ~bp_skip_q;

    // Core enable decode from state; the encoding 11 behaves as HALT.
    always_comb begin
        case (state_q)
            ST_RUN:  w_core_en = ~w_bp_match;
            ST_STEP: w_core_en = 1'b1;
            default: w_core_en = 1'b0;
        endcase
    end

    // An instruction ends on the execute-phase edge that the core takes.
    assign w_boundary = w_core_en & phase;

    // Next-state logic for the sequencer, breakpoint flags and cycle counter.
    always_comb begin
        state_d     = state_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;
        halt_pend_d = halt_pend_q;
        bp_skip_d   = bp_skip_q;

        // The skip window covers exactly one instruction.
        if (w_boundary) begin
            bp_skip_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (w_bp_match) begin
                    // Breakpoint beats any pending halt request.
                    state_d     = ST_HALT;
                    bp_hit_d    = 1'b1;
                    halt_pend_d = 1'b0;
                end else if (w_boundary && (halt_pend_q || halt_req)) begin
                    state_d     = ST_HALT;
                    halt_pend_d = 1'b0;
                end else if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (w_boundary) begin
                    state_d     = ST_HALT;
                    step_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
                if (run_req || step_req) begin
                    // Resuming from a breakpoint must let the instruction at
                    // bp_addr execute once without re-triggering.
                    if (bp_hit_q) begin
                        bp_skip_d = 1'b1;
                    end
                    bp_hit_d = 1'b0;
                end
            end
        endcase

        if (cnt_clr) begin
            cycle_cnt_d = '0;
        end else if (w_core_en && (cycle_cnt_q != C_CNT_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + C_CNT_ONE;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // State and status registers, asynchronously reset together with the core.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= C_RESET_STATE;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            halt_pend_q <= 1'b0;
            bp_skip_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            halt_pend_q <= halt_pend_d;
            bp_skip_q   <= bp_skip_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign core_en   = w_core_en;
    assign halted    = (state_q != ST_RUN) && (state_q != ST_STEP);
    assign bp_hit    = bp_hit_q;
    assign step_done = step_done_q;
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_nibbler_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibbler_run_ctrl
//  Description : Self-checking bench for nibbler_run_ctrl with a simple
//                Nibbler core model, a behavioural reference model and a
//                scoreboard queue drained by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibbler_run_ctrl;

    localparam int ADDR_W = 12;
    localparam int CYC_W  = 4;
    localparam int CMAX   = 15;

    logic              clk;
    logic              Rst;
    logic              run_req, halt_req, step_req, cnt_clr;
    logic              phase;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
    logic              core_en, halted, bp_hit, step_done;
    logic [CYC_W-1:0]  cycle_cnt;
    logic [1:0]        state;

    // Second instance: default parameters, reset into RUN.
    logic              phase2;
    logic [ADDR_W-1:0] pc2;
    logic              bp_en2;
    logic              core_en2, halted2, bp_hit2, step_done2;
    logic [15:0]       cycle_cnt2;
    logic [1:0]        state2;

    // Core program: straight-line except one jump jmp_at -> jmp_to.
    logic [ADDR_W-1:0] jmp_at, jmp_to;
    logic              nxt_bp_en;
    logic [ADDR_W-1:0] nxt_bp_addr;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_no   = 0;

    logic [9:0] sbq[$];

    // Reference model state: m_st 0 = halted, 1 = running, 2 = stepping.
    int m_st, m_cnt;
    bit m_hit, m_pend, m_skip, m_done;

    nibbler_run_ctrl #(.ADDR_W(ADDR_W), .CYC_W(CYC_W), .RUN_ON_RESET(1'b0)) dut (
        .clk(clk), .Rst(Rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .cnt_clr(cnt_clr), .phase(phase), .pc(pc),
        .bp_addr(bp_addr), .bp_en(bp_en), .core_en(core_en), .halted(halted),
        .bp_hit(bp_hit), .step_done(step_done), .cycle_cnt(cycle_cnt), .state(state)
    );

    nibbler_run_ctrl dut_r1 (
        .clk(clk), .Rst(Rst), .run_req(1'b0), .halt_req(1'b0),
        .step_req(1'b0), .cnt_clr(1'b0), .phase(phase2), .pc(pc2),
        .bp_addr(pc2), .bp_en(bp_en2), .core_en(core_en2), .halted(halted2),
        .bp_hit(bp_hit2), .step_done(step_done2), .cycle_cnt(cycle_cnt2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibbler core model: phase toggles, PC advances at the end of execute.
    always @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            phase <= 1'b0;
            pc    <= '0;
        end else if (core_en) begin
            phase <= ~phase;
            if (phase) pc <= (pc == jmp_at) ? jmp_to : pc + 12'd1;
        end
    end

    always @(posedge clk or negedge Rst) begin
        if (!Rst) phase2 <= 1'b0;
        else if (core_en2) phase2 <= ~phase2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc_no, act, exp);
        end
    endtask

    // Monitor: compares every presented output sample with the oldest expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            logic [9:0] e;
            e = sbq.pop_front();
            chk("scoreboard{en,halted,hit,done,state,cnt}",
                {22'd0, core_en, halted, bp_hit, step_done, state, cycle_cnt}, {22'd0, e});
        end
    end

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_hit = 0; m_pend = 0; m_skip = 0; m_done = 0;
    endtask

    // One core clock: apply inputs, predict this cycle's outputs, advance the model.
    task automatic cycle(input bit r, input bit h, input bit s, input bit c);
        bit match, en, bnd;
        @(posedge clk);
        #1;
        cyc_no++;
        run_req = r; halt_req = h; step_req = s; cnt_clr = c;
        bp_en = nxt_bp_en; bp_addr = nxt_bp_addr;

        match = bp_en && (pc == bp_addr) && !phase && !m_skip;
        en    = (m_st == 1) ? !match : (m_st == 2);
        sbq.push_back({en, (m_st == 0), m_hit, m_done, 2'(m_st), 4'(m_cnt)});

        bnd    = en && phase;
        m_done = 0;
        if (bnd) m_skip = 0;
        if (m_st == 0) begin
            if (r || s) begin
                if (m_hit) m_skip = 1;
                m_hit = 0;
                m_st  = r ? 1 : 2;
            end
        end else if (m_st == 1) begin
            if (match) begin
                m_st = 0; m_hit = 1; m_pend = 0;
            end else if (bnd && (m_pend || h)) begin
                m_st = 0; m_pend = 0;
            end else if (h) begin
                m_pend = 1;
            end
        end else if (bnd) begin
            m_st = 0; m_done = 1;
        end
        if (c) m_cnt = 0;
        else if (en && m_cnt < CMAX) m_cnt = m_cnt + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must take reset values at once.
    task automatic do_reset();
        @(posedge clk);
        #2;
        run_req = 0; halt_req = 0; step_req = 0; cnt_clr = 0;
        Rst = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        chk("reset_outputs", {22'd0, core_en, halted, bp_hit, step_done, state, cycle_cnt},
            {22'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0});
        chk("reset_r1_state", {30'd0, state2}, 32'd1);
        @(negedge clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("r1_core_en_after_release", {31'd0, core_en2}, 32'd1);
        chk("r1_halted_after_release", {31'd0, halted2}, 32'd0);
    endtask

    initial begin
        Rst = 1'b0;
        run_req = 0; halt_req = 0; step_req = 0; cnt_clr = 0;
        bp_en = 0; bp_addr = '0; nxt_bp_en = 0; nxt_bp_addr = '0;
        pc2 = '0; bp_en2 = 1'b0;
        jmp_at = 12'hFFF; jmp_to = 12'h000;
        model_reset();

        do_reset();
        idle(4);                       // halted, counter at zero
        cycle(0, 0, 1, 0);             // single step: two enabled cycles
        idle(4);

        nxt_bp_en = 1; nxt_bp_addr = 12'h005;
        jmp_at = 12'h006; jmp_to = 12'h005;
        cycle(1, 0, 0, 0);             // run to breakpoint at 5
        idle(20);
        cycle(1, 0, 0, 0);             // resume: 5 executes, 6 jumps back to 5
        idle(12);

        nxt_bp_en = 0;
        cycle(1, 0, 0, 0);
        idle(2);
        cycle(0, 1, 0, 0);             // halt request then drain to boundary
        idle(6);
        cycle(1, 0, 0, 0);
        idle(3);
        cycle(0, 1, 0, 0);
        idle(6);
        cycle(1, 0, 1, 0);             // run wins over step, no step_done
        idle(20);                      // counter saturates at 15
        cycle(0, 0, 0, 1);             // clear in an incrementing cycle
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) nxt_bp_en = ~nxt_bp_en;
            if ($urandom_range(0, 31) == 0) nxt_bp_addr = 12'($urandom_range(0, 9));
            jmp_at = 12'h009; jmp_to = 12'h002;
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end

        nxt_bp_en = 0;
        cycle(0, 1, 0, 0);
        idle(6);
        cycle(0, 0, 1, 0);             // enter STEP, then abort by reset
        do_reset();
        idle(6);                       // step_done must stay low
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(2);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
